pifo_pop_scheduler: RTL and testbench
=====================================

Name: pifo_pop_scheduler

Overview:
Credit-based, round-robin scheduler for triggered pops to the subtree RPUs of the vPIFO tree. Each root pop that names subtree k adds that packet's length as credit to RPU k. Each subtree pop result subtracts its length from that RPU's credit. The block issues at most one triggered pop per cycle, with at most one outstanding pop per RPU. It replaces ad-hoc per-RPU credit logic with a single arbitrated pop port in front of the PIFO SRAM top.

Parameters:
LEVEL, 4, number of RPUs; RPU 0 is the root and is never scheduled.
TREE_NUM, 4, number of tree ids; TREE_NUM_BITS = $clog2(TREE_NUM).
PLW, 4, packet length width.
CDW, 16, signed credit width per RPU.
LEVEL_BITS, $clog2(LEVEL), localparam.

Ports:
i_clk  in  1  clock
i_arst_n  in  1  asynchronous active-low reset
i_root_pop_valid  in  1  root RPU produced an element this cycle
i_root_pop_tree_id  in  TREE_NUM_BITS  tree id carried in the root element's metadata
i_root_pop_len  in  PLW  length field of the root element
i_sub_pop_valid  in  LEVEL  per-RPU subtree pop result valid (bit 0 ignored)
i_sub_pop_len  in  LEVEL*PLW  per-RPU result length; RPU i occupies bits [i*PLW +: PLW]
i_pop_ready  in  1  PIFO can accept a triggered pop (task FIFO not full)
o_pop_valid  out  1  triggered pop request
o_pop_rpu_id  out  LEVEL_BITS  target RPU; target tree id = o_pop_rpu_id
o_idle  out  1  no outstanding pops and all credits <= 0
o_err  out  1  sticky protocol-error flag

Behaviour:
- State per RPU i (1..LEVEL-1):
  - credit[i]: signed CDW.
  - outst[i]: 1 bit.
  - Shared round-robin pointer rr_ptr, LEVEL_BITS wide.
- Reset values:
  - credit = 0, outst = 0, rr_ptr = 1, o_err = 0.
  - Outputs at reset: o_pop_valid = 0, o_pop_rpu_id = 0, o_idle = 1.
- Root mapping: tgt = i_root_pop_tree_id % LEVEL.
  - tgt == 0 with valid → no credit change; o_err sets next cycle.
- Credit update (registered), per RPU i:
  - credit_next = credit + (root add if i_root_pop_valid && tgt == i ? i_root_pop_len : 0) - (i_sub_pop_valid[i] ? len_i : 0).
  - Lengths are zero-extended to CDW.
  - Add and subtract in the same cycle are both applied.
  - Result saturates to [-2^(CDW-1), 2^(CDW-1)-1].
- Eligibility: elig[i] = credit[i] > 0 && !outst[i]. Uses registered values only, so a credit change is visible one cycle later.
- Arbitration (combinational on registered state):
  - Grant the first elig[i] scanning rr_ptr, rr_ptr+1, …, wrapping from LEVEL-1 back to 1; RPU 0 is skipped.
  - o_pop_valid = |elig; o_pop_rpu_id = grant index, or 0 when none is eligible.
- Handshake:
  - Pop accepted when o_pop_valid && i_pop_ready.
  - On accept: outst[grant] <= 1, and rr_ptr <= next index after grant (skipping 0).
  - No accept → rr_ptr holds; o_pop_valid/o_pop_rpu_id stay stable until accepted or until eligibility changes.
- Completion: i_sub_pop_valid[i] clears outst[i].
  - If outst[i] == 0 at that time: o_err sets, and the subtraction is still applied.
  - A completion and a new grant cannot target the same RPU in one cycle, because grant requires !outst.
- Latency:
  - Root credit at cycle N → o_pop_valid at N+1, given ready.
  - Completion at cycle N → same RPU re-eligible at N+1.
- Negative credit (short-packet borrow) blocks further pops until root credit restores it above 0.
- o_idle = all outst == 0 && all credit <= 0; registered-state combinational.
- o_err is cleared only by reset.
- Reset mid-operation clears all state immediately; in-flight PIFO results arriving after reset are counted as spurious completions (o_err = 1).

Test Plan:
- Reset → o_pop_valid = 0, o_idle = 1, o_err = 0; root pop tree_id = 2, len = 5 at cycle 0 → cycle 1: o_pop_valid = 1, o_pop_rpu_id = 2; accept → outst[2] = 1, valid drops at cycle 2.
- Credits 3 on RPUs 1, 2, 3 with i_pop_ready = 1 → grants 1, 2, 3 on consecutive cycles. Hold ready = 0 for 3 cycles with RPU 1 eligible → o_pop_rpu_id stable at 1, rr_ptr unchanged.
- RPU 1 credit 4, pop accepted, completion len 6 → credit −2, not eligible. Root add len 3 → credit 1, pop issued the next cycle.
- Same cycle: root add len 4 to RPU 3 and completion len 4 on RPU 3 (credit 4 before) → credit 4, outst cleared, RPU 3 re-granted the next cycle.
- Root pop tree_id = 0, or completion on an RPU with outst = 0 → o_err = 1 sticky, credits otherwise as specified. Credit at 32767 plus len 15 → stays 32767.
- Assert reset while outst[2] = 1 and credit[2] = 7 → all cleared, o_idle = 1. A following i_sub_pop_valid[2] sets o_err.

Source files
------------

// File: rtl/pifo_pop_scheduler.sv
// rtl/pifo_pop_scheduler.sv - credit-based round-robin triggered-pop scheduler for vPIFO subtree RPUs
//
// Root pops add their length as credit to the subtree RPU named by the
// element's tree id. Subtree pop results subtract their length again. At most
// one triggered pop is requested per cycle, and each RPU has at most one
// triggered pop outstanding. RPUs are served round-robin among those with
// positive credit.
//
// Ports:
//   i_clk, i_arst_n        clock, asynchronous active-low reset
//   i_root_pop_valid       root RPU produced an element this cycle
//   i_root_pop_tree_id     tree id of that element (target RPU = id % LEVEL)
//   i_root_pop_len         length of that element (credit to add)
//   i_sub_pop_valid        per-RPU subtree pop result valid (bit 0 ignored)
//   i_sub_pop_len          per-RPU result length, RPU i at [i*PLW +: PLW]
//   i_pop_ready            PIFO can accept a triggered pop
//   o_pop_valid            triggered pop request
//   o_pop_rpu_id           target RPU / tree id of the request
//   o_idle                 nothing outstanding and no positive credit
//   o_err                  sticky protocol error
module pifo_pop_scheduler #(
    parameter int LEVEL    = 4,
    parameter int TREE_NUM = 4,
    parameter int PLW      = 4,
    parameter int CDW      = 16,
    localparam int TREE_NUM_BITS = $clog2(TREE_NUM),
    localparam int LEVEL_BITS    = $clog2(LEVEL)
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic                     i_root_pop_valid,
    input  logic [TREE_NUM_BITS-1:0] i_root_pop_tree_id,
    input  logic [PLW-1:0]           i_root_pop_len,
    input  logic [LEVEL-1:0]         i_sub_pop_valid,
    input  logic [LEVEL*PLW-1:0]     i_sub_pop_len,
    input  logic                     i_pop_ready,
    output logic                     o_pop_valid,
    output logic [LEVEL_BITS-1:0]    o_pop_rpu_id,
    output logic                     o_idle,
    output logic                     o_err
);

    // Credit arithmetic runs two bits wider than the stored credit so that
    // credit + add - sub can never wrap before the saturation clamp.
    localparam logic signed [CDW+1:0] CRED_MAX  = {3'b000, {(CDW-1){1'b1}}};
    localparam logic signed [CDW+1:0] CRED_MIN  = {3'b111, {(CDW-1){1'b0}}};
    localparam logic signed [CDW-1:0] CRED_ZERO = '0;
    // RPU 0 is the root: it never receives credit and its results are ignored.
    localparam logic [LEVEL-1:0]      SUB_MASK  = {{(LEVEL-1){1'b1}}, 1'b0};

    logic signed [CDW-1:0]  credit_q [LEVEL];
    logic signed [CDW-1:0]  credit_d [LEVEL];
    logic [LEVEL-1:0]       outst_q, outst_d;
    logic [LEVEL_BITS-1:0]  rr_ptr_q, rr_ptr_d;
    logic                   err_q, err_d;

    int                     root_tgt;
    logic [LEVEL-1:0]       elig;
    logic                   found_hi, found_lo;
    logic [LEVEL_BITS-1:0]  idx_hi, idx_lo;
    logic                   grant_found;
    logic [LEVEL_BITS-1:0]  grant_idx;
    logic                   pop_accept;
    logic                   spurious;
    logic                   idle;

    logic signed [CDW+1:0]  add_ext, sub_ext, sum;

    logic                   unused_rpu0;
    assign unused_rpu0 = ^{i_sub_pop_valid[0], i_sub_pop_len[PLW-1:0]};

    assign root_tgt = int'(i_root_pop_tree_id) % LEVEL;

    // Eligibility looks only at registered state, so new credit or a
    // completion becomes visible to the arbiter one cycle later.
    always_comb begin
        elig = '0;
        for (int i = 1; i < LEVEL; i++) begin
            elig[i] = (credit_q[i] > CRED_ZERO) && !outst_q[i];
        end
    end

    // Round-robin: the first eligible RPU at or above rr_ptr wins; if none,
    // the first eligible RPU below rr_ptr (wrap-around, skipping RPU 0).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = 1; i < LEVEL; i++) begin
            if (elig[i]) begin
                if (i >= int'(rr_ptr_q)) begin
                    if (!found_hi) begin
                        found_hi = 1'b1;
                        idx_hi   = LEVEL_BITS'(i);
                    end
                end else begin
                    if (!found_lo) begin
                        found_lo = 1'b1;
                        idx_lo   = LEVEL_BITS'(i);
                    end
                end
            end
        end
        grant_found = found_hi || found_lo;
        grant_idx   = found_hi ? idx_hi : (found_lo ? idx_lo : '0);
    end

    assign pop_accept = grant_found && i_pop_ready;

    // Saturating credit update; a root add and a completion in the same
    // cycle on the same RPU are both applied.
    always_comb begin
        add_ext     = '0;
        sub_ext     = '0;
        sum         = '0;
        credit_d[0] = '0;
        for (int i = 1; i < LEVEL; i++) begin
            add_ext = (i_root_pop_valid && (root_tgt == i))
                    ? (CDW+2)'(i_root_pop_len) : '0;
            sub_ext = i_sub_pop_valid[i]
                    ? (CDW+2)'(i_sub_pop_len[i*PLW +: PLW]) : '0;
            sum     = (CDW+2)'(credit_q[i]) + add_ext - sub_ext;
            if (sum > CRED_MAX) begin
                credit_d[i] = CRED_MAX[CDW-1:0];
            end else if (sum < CRED_MIN) begin
                credit_d[i] = CRED_MIN[CDW-1:0];
            end else begin
                credit_d[i] = sum[CDW-1:0];
            end
        end
    end

    // Completions clear outstanding; a granted pop sets it. The grant cannot
    // target an RPU with a legitimate completion since it requires !outst.
    always_comb begin
        outst_d    = outst_q & ~i_sub_pop_valid;
        outst_d[0] = 1'b0;
        if (pop_accept) begin
            outst_d[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (pop_accept) begin
            rr_ptr_d = (grant_idx == LEVEL_BITS'(LEVEL - 1))
                     ? LEVEL_BITS'(1) : grant_idx + 1'b1;
        end
    end

    // Errors: a root element mapped to the root itself, or a result for an
    // RPU that had no triggered pop in flight.
    assign spurious = |(i_sub_pop_valid & ~outst_q & SUB_MASK);
    assign err_d    = err_q | spurious | (i_root_pop_valid && (root_tgt == 0));

    always_comb begin
        idle = (outst_q == '0);
        for (int i = 1; i < LEVEL; i++) begin
            if (credit_q[i] > CRED_ZERO) begin
                idle = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int i = 0; i < LEVEL; i++) begin
                credit_q[i] <= '0;
            end
            outst_q  <= '0;
            rr_ptr_q <= LEVEL_BITS'(1);
            err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < LEVEL; i++) begin
                credit_q[i] <= credit_d[i];
            end
            outst_q  <= outst_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    assign o_pop_valid  = grant_found;
    assign o_pop_rpu_id = grant_idx;
    assign o_idle       = idle;
    assign o_err        = err_q;

endmodule

// File: tb/tb_pifo_pop_scheduler.sv
// tb/tb_pifo_pop_scheduler.sv - self-checking bench for pifo_pop_scheduler
module tb_pifo_pop_scheduler;

    localparam int LEVEL    = 4;
    localparam int TREE_NUM = 4;
    localparam int PLW      = 4;
    localparam int CDW      = 16;
    localparam int TNB      = $clog2(TREE_NUM);
    localparam int LB       = $clog2(LEVEL);
    localparam int CMAX     = (1 << (CDW - 1)) - 1;
    localparam int CMIN     = -(1 << (CDW - 1));

    logic                   i_clk = 1'b0;
    logic                   i_arst_n = 1'b0;
    logic                   i_root_pop_valid = 1'b0;
    logic [TNB-1:0]         i_root_pop_tree_id = '0;
    logic [PLW-1:0]         i_root_pop_len = '0;
    logic [LEVEL-1:0]       i_sub_pop_valid = '0;
    logic [LEVEL*PLW-1:0]   i_sub_pop_len = '0;
    logic                   i_pop_ready = 1'b0;
    logic                   o_pop_valid;
    logic [LB-1:0]          o_pop_rpu_id;
    logic                   o_idle;
    logic                   o_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_cred [LEVEL];
    bit m_out  [LEVEL];
    int m_rr;
    bit m_err;

    pifo_pop_scheduler #(
        .LEVEL    (LEVEL),
        .TREE_NUM (TREE_NUM),
        .PLW      (PLW),
        .CDW      (CDW)
    ) dut (
        .i_clk              (i_clk),
        .i_arst_n           (i_arst_n),
        .i_root_pop_valid   (i_root_pop_valid),
        .i_root_pop_tree_id (i_root_pop_tree_id),
        .i_root_pop_len     (i_root_pop_len),
        .i_sub_pop_valid    (i_sub_pop_valid),
        .i_sub_pop_len      (i_sub_pop_len),
        .i_pop_ready        (i_pop_ready),
        .o_pop_valid        (o_pop_valid),
        .o_pop_rpu_id       (o_pop_rpu_id),
        .o_idle             (o_idle),
        .o_err              (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LEVEL; i++) begin
            m_cred[i] = 0;
            m_out[i]  = 0;
        end
        m_rr  = 1;
        m_err = 0;
    endtask

    // Walk RPUs starting at the pointer, wrapping past LEVEL-1 to 1.
    function automatic int model_grant();
        int idx;
        for (int k = 0; k < LEVEL - 1; k++) begin
            idx = m_rr + k;
            if (idx > LEVEL - 1) idx -= (LEVEL - 1);
            if (m_cred[idx] > 0 && !m_out[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic set_root(input int tid, input int len);
        i_root_pop_valid   = 1'b1;
        i_root_pop_tree_id = TNB'(tid);
        i_root_pop_len     = PLW'(len);
    endtask

    task automatic set_sub(input int rpu, input int len);
        i_sub_pop_valid[rpu]          = 1'b1;
        i_sub_pop_len[rpu*PLW +: PLW] = PLW'(len);
    endtask

    // Check outputs against the model, advance the model with the driven
    // inputs, clock once, then drop the one-shot inputs.
    task automatic cycle();
        int g, tgt, c;
        bit idle_e;
        g = model_grant();
        idle_e = 1;
        for (int i = 1; i < LEVEL; i++) begin
            if (m_out[i] || m_cred[i] > 0) idle_e = 0;
        end
        chk("pop_valid", o_pop_valid, (g != 0));
        chk("pop_rpu_id", o_pop_rpu_id, g);
        chk("idle", o_idle, idle_e);
        chk("err", o_err, m_err);

        tgt = int'(i_root_pop_tree_id) % LEVEL;
        if (i_root_pop_valid && tgt == 0) m_err = 1;
        for (int i = 1; i < LEVEL; i++) begin
            c = m_cred[i];
            if (i_root_pop_valid && tgt == i) c += int'(i_root_pop_len);
            if (i_sub_pop_valid[i]) begin
                c -= int'(i_sub_pop_len[i*PLW +: PLW]);
                if (!m_out[i]) m_err = 1;
                m_out[i] = 0;
            end
            if (c > CMAX) c = CMAX;
            if (c < CMIN) c = CMIN;
            m_cred[i] = c;
        end
        if (g != 0 && i_pop_ready) begin
            m_out[g] = 1;
            m_rr = (g == LEVEL - 1) ? 1 : g + 1;
        end

        @(posedge i_clk);
        #1;
        i_root_pop_valid = 1'b0;
        i_sub_pop_valid  = '0;
        i_sub_pop_len    = '0;
    endtask

    task automatic do_reset();
        i_arst_n         = 1'b0;
        i_root_pop_valid = 1'b0;
        i_sub_pop_valid  = '0;
        i_sub_pop_len    = '0;
        #3;
        i_arst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        do_reset();

        // Reset state, first credit, first grant and accept
        i_pop_ready = 1'b1;
        chk("rst_valid", o_pop_valid, 0);
        chk("rst_id", o_pop_rpu_id, 0);
        chk("rst_idle", o_idle, 1);
        chk("rst_err", o_err, 0);
        set_root(2, 5);
        cycle();
        chk("first_valid", o_pop_valid, 1);
        chk("first_id", o_pop_rpu_id, 2);
        cycle();
        chk("accept_drop", o_pop_valid, 0);
        chk("accept_busy", o_idle, 0);
        set_sub(2, 5);
        cycle();
        chk("done_idle", o_idle, 1);

        // Round-robin over three RPUs, then hold under backpressure
        do_reset();
        i_pop_ready = 1'b0;
        set_root(1, 3); cycle();
        set_root(2, 3); cycle();
        set_root(3, 3); cycle();
        i_pop_ready = 1'b1;
        chk("rr_g1", o_pop_rpu_id, 1); cycle();
        chk("rr_g2", o_pop_rpu_id, 2); cycle();
        chk("rr_g3", o_pop_rpu_id, 3); cycle();
        chk("rr_none", o_pop_valid, 0);
        set_sub(1, 3); set_sub(2, 3); set_sub(3, 3);
        cycle();
        i_pop_ready = 1'b0;
        set_root(1, 2); cycle();
        set_root(3, 2);
        for (int k = 0; k < 3; k++) begin
            chk("hold_id", o_pop_rpu_id, 1);
            cycle();
        end
        i_pop_ready = 1'b1;
        chk("hold_rel1", o_pop_rpu_id, 1); cycle();
        chk("hold_rel3", o_pop_rpu_id, 3); cycle();
        set_sub(1, 2); set_sub(3, 2);
        cycle();

        // Negative credit borrow and restore
        do_reset();
        i_pop_ready = 1'b1;
        set_root(1, 4); cycle();
        cycle();
        set_sub(1, 6); cycle();
        chk("neg_valid", o_pop_valid, 0);
        chk("neg_idle", o_idle, 1);
        set_root(1, 3); cycle();
        chk("restore_valid", o_pop_valid, 1);
        chk("restore_id", o_pop_rpu_id, 1);
        cycle();
        set_sub(1, 1); cycle();

        // Same-cycle add and completion on RPU 3
        do_reset();
        i_pop_ready = 1'b1;
        set_root(3, 4); cycle();
        cycle();
        set_root(3, 4); set_sub(3, 4); cycle();
        chk("same_valid", o_pop_valid, 1);
        chk("same_id", o_pop_rpu_id, 3);
        cycle();
        set_sub(3, 4); cycle();

        // Error conditions
        do_reset();
        set_root(0, 5); cycle();
        chk("err_root0", o_err, 1);
        chk("err_root0_idle", o_idle, 1);
        cycle();
        chk("err_sticky", o_err, 1);
        do_reset();
        set_sub(2, 3); cycle();
        chk("err_spurious", o_err, 1);
        chk("spurious_valid", o_pop_valid, 0);
        set_root(2, 3); cycle();
        cycle();
        chk("spurious_zero", o_pop_valid, 0);

        // Positive saturation
        do_reset();
        i_pop_ready = 1'b0;
        repeat (2185) begin
            set_root(1, 15);
            cycle();
        end
        set_root(1, 15); cycle();
        chk("sat_valid", o_pop_valid, 1);
        chk("sat_id", o_pop_rpu_id, 1);
        i_pop_ready = 1'b1;
        cycle();
        set_sub(1, 15); cycle();
        chk("sat_sub_valid", o_pop_valid, 1);

        // Asynchronous reset mid-operation
        do_reset();
        i_pop_ready = 1'b0;
        set_root(2, 7); cycle();
        i_pop_ready = 1'b1;
        cycle();
        i_pop_ready = 1'b0;
        chk("mid_busy", o_idle, 0);
        i_arst_n = 1'b0;
        #2;
        chk("mid_rst_valid", o_pop_valid, 0);
        chk("mid_rst_idle", o_idle, 1);
        chk("mid_rst_err", o_err, 0);
        #1;
        i_arst_n = 1'b1;
        model_reset();
        set_sub(2, 5); cycle();
        chk("mid_late_err", o_err, 1);

        // Randomized traffic against the model
        do_reset();
        repeat (1500) begin
            i_pop_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                set_root(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            end
            for (int i = 1; i < LEVEL; i++) begin
                if (m_out[i] && $urandom_range(0, 2) == 0) begin
                    set_sub(i, int'($urandom_range(0, 15)));
                end else if (!m_out[i] && !i_pop_ready && $urandom_range(0, 49) == 0) begin
                    set_sub(i, int'($urandom_range(0, 15)));
                end
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
